id_ex_stage: RTL
================

# id_ex_stage

Pipeline boundary between decode (ID) and execute (EX) of the 5-stage MIPS core. Each cycle it registers the control unit's outputs (RegDst, branch, Memread, MemtoReg, MemWrite, AluSrc, RegWrite, ALUop) together with the decoded operands. It detects load-use hazards against the instruction currently in EX, raises a stall to hold PC and IF/ID, and inserts bubbles. It also squashes the ID instruction on a taken-branch flush.

## Interface
Parameters:
- DW, 32, datapath width (register data, immediate, PC+4)
- RW, 5, register-specifier width
- CW, 16, width of the bubble counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- id_RegDst, id_branch, id_Memread, id_MemtoReg, id_MemWrite, id_AluSrc, id_RegWrite  in  1 each  control unit outputs for the ID instruction
- id_ALUop  in  4  control unit ALU operation code
- id_rd1, id_rd2  in  DW  register-file read data
- id_imm  in  DW  sign-extended immediate
- id_pc4  in  DW  PC+4 of the ID instruction
- id_rs, id_rt, id_rd  in  RW  instruction register fields
- flush  in  1  taken branch resolved downstream; squash the ID instruction
- ex_RegDst … ex_RegWrite, ex_ALUop, ex_rd1, ex_rd2, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd  out  same widths  registered copies for EX
- stall  out  1  combinational; holds PC and IF/ID this cycle
- bubble_count  out  CW  saturating count of hazard bubbles inserted

## Operation
- **Hazard detect (comb):** hazard = ex_Memread & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
- **Stall:** stall = hazard & ~flush. A flush suppresses the stall because the ID instruction is wrong-path.
- **Capture priority at each posedge clk:**
  - flush: load a bubble.
  - hazard (not flushed): load a bubble.
  - otherwise: load all id_* inputs.
- **Bubble definition:**
  - All seven 1-bit controls = 0 and ex_ALUop = 4'b0000.
  - Data and specifier fields (ex_rd1, ex_rd2, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd) = 0.
- **bubble_count:** increments by 1 on each hazard bubble, i.e. only when stall=1 at the edge. Flush bubbles do not count. Saturates at all-ones; never wraps.
- **Don't-care controls:** an X on id_RegDst (sw/beq) is registered as-is; no cleaning is done.

## Timing
- Latency: 1 cycle. An id_* value present before edge N appears on ex_* after edge N.
- stall is valid in the same cycle as the hazard, from the registered ex_Memread/ex_rt.
  - After the bubble is written, ex_Memread=0, so stall deasserts the next cycle. A single load-use costs exactly one bubble.
- **Reset:** asynchronous, takes effect immediately with no clock needed.
  - All ex_* outputs = 0 and bubble_count = 0.
  - Therefore stall = 0 during and directly after reset.
  - Reset mid-stall aborts the stall immediately; the first capture after reset release is a normal load.
- **Simultaneous hazard + flush:** produces a bubble, stall=0, bubble_count unchanged.
- **Back-to-back loads** where the second depends on the first: one bubble, then the second lw enters EX normally.
- **Load to $0:** never stalls.

## Configuration
- Macro: ID_EX_HAZARD_STALL_EN.
- **Defined:** load-use detection, stall generation, hazard bubbles and bubble_count behave as above.
- **Undefined:**
  - hazard is tied 0, so stall is constant 0.
  - bubble_count is constant 0 and its register is not built.
  - Only flush inserts bubbles; software must schedule delay slots.

## Test plan
- **Reset:** assert reset between clock edges with all id_* = 1s. Required: all ex_* and bubble_count go to 0 without a clock edge; stall=0.
- **Normal pass-through:** R-type controls (RegDst=1, RegWrite=1, ALUop=0010), id_rd1=0x1234, id_rt=5. Required: values appear on ex_* one edge later; stall stays 0.
- **Load-use:** lw (Memread=1, rt=8) in EX, ID has rs=8. Required: stall=1 that cycle; next edge loads a bubble (all controls 0); bubble_count=1; stall=0 the following cycle.
- **Hazard + flush:** the load-use condition above with flush=1 in the same cycle. Required: stall=0, bubble loaded, bubble_count unchanged.
- **$0 exemption:** lw with rt=0 in EX, ID rs=0. Required: no stall, normal capture.
- **Saturation:** preload or force bubble_count=0xFFFE, then three load-use events. Required: count sequence 0xFFFF, 0xFFFF, 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard stall and flush squash.
// Optional: define ID_EX_HAZARD_STALL_EN to build load-use detection and the bubble counter.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_RegDst,
    input  logic          id_branch,
    input  logic          id_Memread,
    input  logic          id_MemtoReg,
    input  logic          id_MemWrite,
    input  logic          id_AluSrc,
    input  logic          id_RegWrite,
    input  logic [3:0]    id_ALUop,
    input  logic [DW-1:0] id_rd1,
    input  logic [DW-1:0] id_rd2,
    input  logic [DW-1:0] id_imm,
    input  logic [DW-1:0] id_pc4,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic          flush,
    output logic          ex_RegDst,
    output logic          ex_branch,
    output logic          ex_Memread,
    output logic          ex_MemtoReg,
    output logic          ex_MemWrite,
    output logic          ex_AluSrc,
    output logic          ex_RegWrite,
    output logic [3:0]    ex_ALUop,
    output logic [DW-1:0] ex_rd1,
    output logic [DW-1:0] ex_rd2,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_pc4,
    output logic [RW-1:0] ex_rs,
    output logic [RW-1:0] ex_rt,
    output logic [RW-1:0] ex_rd,
    output logic          stall,
    output logic [CW-1:0] bubble_count
);

    typedef struct packed {
        logic          reg_dst;
        logic          branch;
        logic          memread;
        logic          memtoreg;
        logic          memwrite;
        logic          alusrc;
        logic          regwrite;
        logic [3:0]    aluop;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc4;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
    } ex_t;

    ex_t  id_pkt, ex_d, ex_q;
    logic hazard;

    assign id_pkt = {id_RegDst, id_branch, id_Memread, id_MemtoReg, id_MemWrite,
                     id_AluSrc, id_RegWrite, id_ALUop, id_rd1, id_rd2, id_imm,
                     id_pc4, id_rs, id_rt, id_rd};

`ifdef ID_EX_HAZARD_STALL_EN
    assign hazard = ex_q.memread & (ex_q.rt != '0) &
                    ((ex_q.rt == id_rs) | (ex_q.rt == id_rt));
`else
    assign hazard = 1'b0;
`endif

    // A flushed ID instruction is wrong-path, so holding the front end is pointless.
    assign stall = hazard & ~flush;

    always_comb begin
        ex_d = id_pkt;
        if (flush || hazard) ex_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ex_q <= '0;
        else       ex_q <= ex_d;
    end

`ifdef ID_EX_HAZARD_STALL_EN
    logic [CW-1:0] bcnt_d, bcnt_q;

    // Counts hazard bubbles only; saturates instead of wrapping.
    always_comb begin
        bcnt_d = bcnt_q;
        if (stall && (bcnt_q != '1)) bcnt_d = bcnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) bcnt_q <= '0;
        else       bcnt_q <= bcnt_d;
    end

    assign bubble_count = bcnt_q;
`else
    assign bubble_count = '0;
`endif

    assign ex_RegDst   = ex_q.reg_dst;
    assign ex_branch   = ex_q.branch;
    assign ex_Memread  = ex_q.memread;
    assign ex_MemtoReg = ex_q.memtoreg;
    assign ex_MemWrite = ex_q.memwrite;
    assign ex_AluSrc   = ex_q.alusrc;
    assign ex_RegWrite = ex_q.regwrite;
    assign ex_ALUop    = ex_q.aluop;
    assign ex_rd1      = ex_q.rd1;
    assign ex_rd2      = ex_q.rd2;
    assign ex_imm      = ex_q.imm;
    assign ex_pc4      = ex_q.pc4;
    assign ex_rs       = ex_q.rs;
    assign ex_rt       = ex_q.rt;
    assign ex_rd       = ex_q.rd;

endmodule
